bus_word_fifo: RTL

BUS_WORD_FIFO -- requirements
Module: bus_word_fifo

---
 rtl/bus_word_fifo_pkg.sv | 9 +
 rtl/bus_word_fifo_mem.sv | 24 ++
 rtl/bus_word_fifo.sv | 95 +++++++++
 3 files changed

// File: rtl/bus_word_fifo_pkg.sv
// Shared HuC6270 constants for the CPU byte-lane to bus-word FIFO.
// Instances override these through the module parameters.
package bus_word_fifo_pkg;

  localparam int DEF_BYTE_W = 8;
  localparam int DEF_LANES  = 2;
  localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/bus_word_fifo_mem.sv
// Word storage for bus_word_fifo: synchronous write, combinational read.
module bus_word_fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; occupancy is tracked by the
  // pointers and count, so stale words are never presented as valid.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bus_word_fifo.sv
// Assembles CPU byte writes into bus words and queues them in a show-ahead
// FIFO; a write to the top lane commits {top byte, held lower lanes}.
module bus_word_fifo
  import bus_word_fifo_pkg::*;
#(
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int LANES  = DEF_LANES,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(LANES)-1:0]   wr_lane,
  input  logic [BYTE_W-1:0]          wr_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BYTE_W*LANES-1:0]    out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       clear_ovf
);

  localparam int LANE_W = $clog2(LANES);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = BYTE_W * LANES;
  localparam int HOLD_W = BYTE_W * (LANES - 1);

  logic [HOLD_W-1:0] hold;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              commit;
  logic              pop;
  logic              push;
  logic              drop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign out_valid = !empty;

  // Lane codes at or above LANES never match, so they fall through as no-ops.
  always_comb begin
    commit = wr_en && (wr_lane == LANE_W'(LANES - 1));
    pop    = out_valid && out_ready;
    push   = commit && (!full || pop);
    drop   = commit && full && !pop;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold <= '0;
    end else if (wr_en) begin
      for (int l = 0; l < LANES - 1; l++) begin
        if (wr_lane == LANE_W'(l)) hold[l*BYTE_W +: BYTE_W] <= wr_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A dropped commit wins over a same-cycle clear.
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  bus_word_fifo_mem #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data ({wr_data, hold}),
    .rd_addr (rd_ptr),
    .rd_data (out_data)
  );

endmodule
